// File: rtl/fifo_merge2_pkt_if.sv
// Handshake bundle between two upstream FIFOs (EMPTY_N/DEQ), the merge block
// and the downstream FIFO enqueue port (ENQ/FULL_N), plus merge status.
interface fifo_merge2_pkt_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  EMPTY_N0;
    logic                  EMPTY_N1;
    logic [DATA_WIDTH-1:0] D_IN0;
    logic [DATA_WIDTH-1:0] D_IN1;
    logic                  LAST0;
    logic                  LAST1;
    logic                  DEQ0;
    logic                  DEQ1;
    logic                  FULL_N;
    logic                  ENQ;
    logic [DATA_WIDTH-1:0] D_OUT;
    logic                  LAST_OUT;
    logic                  OWNER;
    logic                  LOCKED;
    logic                  ERR;

    modport master (
        output EMPTY_N0, EMPTY_N1, D_IN0, D_IN1, LAST0, LAST1, FULL_N,
        input  DEQ0, DEQ1, ENQ, D_OUT, LAST_OUT, OWNER, LOCKED, ERR
    );

    modport slave (
        input  EMPTY_N0, EMPTY_N1, D_IN0, D_IN1, LAST0, LAST1, FULL_N,
        output DEQ0, DEQ1, ENQ, D_OUT, LAST_OUT, OWNER, LOCKED, ERR
    );
endinterface

// File: rtl/fifo_merge2_pkt.sv
// Two-source packet-aware round-robin merge into a single downstream FIFO.
// Packets are never interleaved; packets longer than MAXLEN beats raise a sticky ERR.
module fifo_merge2_pkt #(
    parameter int DATA_WIDTH = 8,
    parameter int MAXLEN     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    fifo_merge2_pkt_if.slave bus
);
    localparam int CNT_W = $clog2(MAXLEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXLEN);
    localparam logic [CNT_W-1:0] ERR_AT  = CNT_W'(MAXLEN - 1);

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             owner_reg;
    logic             owner_next;
    logic             prio_reg;
    logic             prio_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             err_reg;
    logic             err_next;

    logic                  sel;
    logic                  sel_empty_n;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  xfer;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c >= CNT_MAX) begin
            return CNT_MAX;
        end
        return c + CNT_W'(1);
    endfunction

    // Source selection: a locked packet keeps its owner; otherwise a lone
    // non-empty source wins immediately, ties go to the round-robin pointer.
    always_comb begin
        sel = prio_reg;
        if (state == ST_LOCKED) begin
            sel = owner_reg;
        end else if (bus.EMPTY_N0 && !bus.EMPTY_N1) begin
            sel = 1'b0;
        end else if (!bus.EMPTY_N0 && bus.EMPTY_N1) begin
            sel = 1'b1;
        end
    end

    assign sel_empty_n = sel ? bus.EMPTY_N1 : bus.EMPTY_N0;
    assign sel_last    = sel ? bus.LAST1    : bus.LAST0;
    assign sel_data    = sel ? bus.D_IN1    : bus.D_IN0;

    // RST gates the handshake so nothing moves while reset is held.
    assign xfer = sel_empty_n && bus.FULL_N && !CLR && RST;

    assign bus.ENQ      = xfer;
    assign bus.DEQ0     = xfer && !sel;
    assign bus.DEQ1     = xfer && sel;
    assign bus.D_OUT    = sel_data;
    assign bus.LAST_OUT = sel_last;
    assign bus.OWNER    = owner_reg;
    assign bus.LOCKED   = (state == ST_LOCKED);
    assign bus.ERR      = err_reg;

    always_comb begin
        state_next = state;
        owner_next = owner_reg;
        prio_next  = prio_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        if (CLR) begin
            state_next = ST_OPEN;
            owner_next = 1'b0;
            prio_next  = 1'b0;
            cnt_next   = '0;
            err_next   = 1'b0;
        end else if (xfer) begin
            if (sel_last) begin
                state_next = ST_OPEN;
                prio_next  = !sel;
                cnt_next   = '0;
            end else begin
                state_next = ST_LOCKED;
                owner_next = sel;
                cnt_next   = sat_inc(cnt_reg);
                if (cnt_reg >= ERR_AT) begin
                    err_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_OPEN;
            owner_reg <= 1'b0;
            prio_reg  <= 1'b0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state     <= state_next;
            owner_reg <= owner_next;
            prio_reg  <= prio_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end
endmodule

// File: tb/tb_fifo_merge2_pkt.sv
// Bench for fifo_merge2_pkt: queue-backed source FIFOs, expected-beat scoreboard
// popped by a monitor on every ENQ, and directed checks of the status outputs.
module tb_fifo_merge2_pkt;
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    typedef struct packed {
        logic       src;
        logic       last;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clr;
    logic en0;
    logic en1;
    logic full_n;

    beat_t q0[$];
    beat_t q1[$];
    exp_t  exp_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    fifo_merge2_pkt_if #(.DATA_WIDTH(8)) bus ();

    fifo_merge2_pkt #(
        .DATA_WIDTH(8),
        .MAXLEN    (4)
    ) dut (
        .CLK(clk),
        .RST(rst_n),
        .CLR(clr),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got === want) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic load(input logic s, input logic [7:0] d, input logic l);
        beat_t b;
        b.last = l;
        b.data = d;
        if (s) q1.push_back(b);
        else   q0.push_back(b);
    endtask

    task automatic expect_beat(input logic s, input logic [7:0] d, input logic l);
        exp_t e;
        e.src  = s;
        e.last = l;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic s, input logic [7:0] d, input logic l);
        load(s, d, l);
        expect_beat(s, d, l);
    endtask

    task automatic drive();
        bus.EMPTY_N0 = en0 && (q0.size() != 0);
        bus.D_IN0    = (q0.size() != 0) ? q0[0].data : 8'h00;
        bus.LAST0    = (q0.size() != 0) ? q0[0].last : 1'b0;
        bus.EMPTY_N1 = en1 && (q1.size() != 0);
        bus.D_IN1    = (q1.size() != 0) ? q1[0].data : 8'h00;
        bus.LAST1    = (q1.size() != 0) ? q1[0].last : 1'b0;
        bus.FULL_N   = full_n;
    endtask

    // One clock: capture DEQs mid-cycle, then pop the dequeued heads after the edge.
    task automatic cycle();
        logic d0;
        logic d1;
        @(negedge clk);
        d0 = bus.DEQ0;
        d1 = bus.DEQ1;
        @(posedge clk);
        #1;
        if (d0 && q0.size() != 0) q0.delete(0);
        if (d1 && q1.size() != 0) q1.delete(0);
        drive();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.ENQ) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL spurious_beat: ENQ with data 0x%0h, expected no beat at %0t",
                         bus.D_OUT, $time);
            end else begin
                e = exp_q.pop_front();
                chk("beat{deq1,deq0,last,data}",
                    {21'd0, bus.DEQ1, bus.DEQ0, bus.LAST_OUT, bus.D_OUT},
                    {21'd0, e.src, !e.src, e.last, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n  = 1'b1;
        clr    = 1'b0;
        en0    = 1'b1;
        en1    = 1'b1;
        full_n = 1'b1;
        drive();
        #1 rst_n = 1'b0;

        // Reset with both sources offering single-beat packets
        for (int i = 0; i < 3; i++) begin
            load(1'b0, 8'hA0 + 8'(i), 1'b1);
            load(1'b1, 8'hB0 + 8'(i), 1'b1);
            expect_beat(1'b0, 8'hA0 + 8'(i), 1'b1);
            expect_beat(1'b1, 8'hB0 + 8'(i), 1'b1);
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_enq", bus.ENQ, 0);
        chk("rst_deq0", bus.DEQ0, 0);
        chk("rst_deq1", bus.DEQ1, 0);
        chk("rst_owner", bus.OWNER, 0);
        chk("rst_locked", bus.LOCKED, 0);
        chk("rst_err", bus.ERR, 0);
        rst_n = 1'b1;
        #1;
        chk("first_enq", bus.ENQ, 1);
        chk("first_deq0", bus.DEQ0, 1);

        // Fairness: A0,B0,A1,B1,A2,B2 back to back
        for (int i = 0; i < 6; i++) begin
            cycle();
            #1;
            if (i < 5) chk("rr_enq_every_cycle", bus.ENQ, 1);
        end
        chk("rr_idle", bus.ENQ, 0);

        // Packet lock: source 0 stalls mid-packet, source 1 must wait
        send(1'b0, 8'hC0, 1'b0);
        send(1'b0, 8'hC1, 1'b0);
        send(1'b0, 8'hC2, 1'b1);
        send(1'b1, 8'hD0, 1'b1);
        drive();
        cycle();
        #1;
        chk("lock_locked", bus.LOCKED, 1);
        chk("lock_owner", bus.OWNER, 0);
        cycle();
        en0 = 1'b0;
        drive();
        #1;
        chk("lock_enq_stall", bus.ENQ, 0);
        chk("lock_deq1_stall", bus.DEQ1, 0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            #1;
            chk("lock_deq1_hold", bus.DEQ1, 0);
            chk("lock_locked_hold", bus.LOCKED, 1);
        end
        en0 = 1'b1;
        drive();
        #1;
        chk("lock_resume_deq0", bus.DEQ0, 1);
        cycle();
        #1;
        chk("lock_released", bus.LOCKED, 0);
        chk("lock_src1_next", bus.DEQ1, 1);
        cycle();

        // Backpressure mid-packet
        send(1'b0, 8'hE0, 1'b0);
        send(1'b0, 8'hE1, 1'b0);
        send(1'b0, 8'hE2, 1'b0);
        send(1'b0, 8'hE3, 1'b1);
        drive();
        cycle();
        cycle();
        full_n = 1'b0;
        drive();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_enq", bus.ENQ, 0);
            chk("bp_deq0", bus.DEQ0, 0);
            chk("bp_locked", bus.LOCKED, 1);
            cycle();
        end
        full_n = 1'b1;
        drive();
        cycle();
        #1;
        chk("bp_err_clear", bus.ERR, 0);
        cycle();
        #1;
        chk("bp_unlocked", bus.LOCKED, 0);

        // Overlength: 6-beat packet on source 1 with MAXLEN=4
        for (int i = 0; i < 6; i++) send(1'b1, 8'hF0 + 8'(i), (i == 5));
        drive();
        repeat (3) cycle();
        #1;
        chk("ovl_err_before", bus.ERR, 0);
        cycle();
        #1;
        chk("ovl_err_rise", bus.ERR, 1);
        cycle();
        cycle();
        #1;
        chk("ovl_err_sticky", bus.ERR, 1);
        chk("ovl_unlocked", bus.LOCKED, 0);

        // CLR during beat 2 of a locked source-1 packet
        send(1'b1, 8'h90, 1'b0);
        load(1'b1, 8'h91, 1'b0);
        load(1'b1, 8'h92, 1'b1);
        drive();
        #1;
        chk("clr_lone_src1", bus.DEQ1, 1);
        cycle();
        send(1'b0, 8'h50, 1'b1);
        expect_beat(1'b1, 8'h91, 1'b0);
        expect_beat(1'b1, 8'h92, 1'b1);
        drive();
        #1;
        chk("clr_owner1", bus.OWNER, 1);
        chk("clr_err_pre", bus.ERR, 1);
        clr = 1'b1;
        #1;
        chk("clr_enq", bus.ENQ, 0);
        chk("clr_deq0", bus.DEQ0, 0);
        chk("clr_deq1", bus.DEQ1, 0);
        cycle();
        clr = 1'b0;
        #1;
        chk("clr_locked", bus.LOCKED, 0);
        chk("clr_err", bus.ERR, 0);
        chk("clr_src0_wins", bus.DEQ0, 1);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        #1;
        chk("drain_expected", exp_q.size(), 0);
        chk("drain_sources", q0.size() + q1.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/fifo_merge2_pkt.md
# fifo_merge2_pkt

Two-input packet-aware round-robin merge that feeds the enqueue side of a single depth-1 loopy FIFO. It dequeues beats from two upstream FIFOs (EMPTY_N/DEQ interfaces) and enqueues them into one downstream FIFO (ENQ/FULL_N interface). A packet, terminated by a LAST beat, is never interleaved with the other source. Arbitration is fair round-robin at packet granularity, and overlong packets are flagged.

## Interface
- DATA_WIDTH, 8: width of the data beat.
- MAXLEN, 16: maximum legal beats per packet, ≥1. Longer packets are flagged, not truncated.
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  reset. Reset is asynchronous and active-low; there is one clock.
- CLR  input  1  synchronous clear, same semantics as the FIFO CLR it shares.
- EMPTY_N0 / EMPTY_N1  input  1  source x holds a beat.
- D_IN0 / D_IN1  input  DATA_WIDTH  head beat of source x.
- LAST0 / LAST1  input  1  head beat of source x ends its packet.
- DEQ0 / DEQ1  output  1  dequeue source x this cycle.
- FULL_N  input  1  downstream can accept. May rise combinationally when the downstream is dequeued in the same cycle.
- ENQ  output  1  enqueue D_OUT/LAST_OUT downstream.
- D_OUT  output  DATA_WIDTH  muxed beat from the selected source.
- LAST_OUT  output  1  muxed LAST of the selected source.
- OWNER  output  1  source currently selected (registered owner while locked).
- LOCKED  output  1  a packet is in progress.
- ERR  output  1  sticky: some packet exceeded MAXLEN beats.

## Operation
- State: lock_reg (1b), owner_reg (1b), prio_reg (1b, preferred source when unlocked), cnt_reg (beat count of the current packet, width clog2(MAXLEN+1), saturating at MAXLEN), err_reg.
- Selection, combinational:
  - Locked: sel = owner_reg.
  - Unlocked, only one source non-empty: sel = that source.
  - Unlocked, both non-empty: sel = prio_reg.
  - Unlocked, none non-empty: sel = prio_reg.
- Transfer condition: xfer = EMPTY_N[sel] && FULL_N && !CLR && RST.
  - ENQ = xfer.
  - DEQsel = xfer; DEQ of the other source is 0.
  - D_OUT = D_IN[sel] and LAST_OUT = LAST[sel] at all times.
- No combinational path from any input to FULL_N exists in this block. ENQ depends on FULL_N, never the reverse.
- Update on posedge when xfer:
  - LAST[sel] = 1: lock_reg←0, prio_reg←!sel, cnt_reg←0.
  - LAST[sel] = 0: lock_reg←1, owner_reg←sel, cnt_reg←cnt_reg+1 (saturating).
  - A non-LAST beat taken when cnt_reg+1 ≥ MAXLEN sets err_reg←1.
- Locked and owner empty: block stalls. The other source is never served mid-packet.
- Single-beat packets (LAST on the first beat) never set lock_reg; prio_reg still toggles.
- CLR = 1: no transfer that cycle. Next state: lock_reg=0, owner_reg=0, prio_reg=0, cnt_reg=0, err_reg=0.
- Reset (RST=0, asynchronous):
  - All registers clear to 0.
  - ENQ, DEQ0, DEQ1 are forced 0 while RST=0.
  - OWNER=0, LOCKED=0, ERR=0.
  - Reset mid-packet abandons the packet; there is no recovery of partial state.

## Timing
- Zero-latency pass-through: a beat visible at EMPTY_N/D_IN is enqueued in the same cycle when FULL_N=1.
- Throughput is one beat per cycle, provided the downstream FIFO has FULL_N=1 via simultaneous DEQ.
- Arbitration decisions for a new packet take effect on the same cycle the first beat is available. There is no idle bubble between packets.
- LOCKED, OWNER and ERR reflect state after the previous posedge.
- Warning $display (translate_off) on any of:
  - DEQx while EMPTY_Nx = 0;
  - ENQ while FULL_N = 0;
  - LAST_OUT beat while cnt_reg was saturated.

## Test plan
- **Reset:** RST=0 with both sources non-empty and FULL_N=1 → ENQ=DEQ0=DEQ1=0, OWNER=0, LOCKED=0, ERR=0. After release, the first ENQ takes source 0.
- **Fairness:** both sources continuously offer single-beat packets (LAST=1), D_IN0=0xA0.., D_IN1=0xB0.., FULL_N=1 → D_OUT alternates A0,B0,A1,B1; one ENQ per cycle.
- **Packet lock:** source 0 sends a 3-beat packet and stalls (EMPTY_N0=0) after beat 2 while source 1 is non-empty → DEQ1 stays 0 and LOCKED=1. Beat 3 completes the packet; source 1 is served on the next cycle.
- **Backpressure:** FULL_N=0 for 4 cycles mid-packet → ENQ=DEQx=0, state frozen, cnt_reg unchanged. The stream resumes with no beat lost or duplicated.
- **Overlength:** MAXLEN=4, a 6-beat packet → ERR rises after the 4th non-LAST beat. All 6 beats are still delivered in order. ERR stays 1 until CLR.
- **CLR mid-packet:** CLR=1 during beat 2 of a locked source-1 packet → no ENQ/DEQ that cycle. Next cycle LOCKED=0, ERR=0, prio=0, and source 0 wins if both sources are non-empty.
